// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button conditioner: 2-FF synchroniser, debounce counter, press/release pulses.
// Optional hold-to-repeat pulse generator built only when HOLD_REPEAT_EN is defined.
module multi_button_debouncer #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_down,
    output logic [N_CH-1:0] btn_up,
    output logic [N_CH-1:0] btn_repeat
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_CH-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    logic [N_CH-1:0]  sync_s0_q, sync_s0_d;
    logic [N_CH-1:0]  sync_s1_q, sync_s1_d;
    logic [N_CH-1:0]  state_q, state_d;
    logic [N_CH-1:0]  down_q, down_d;
    logic [N_CH-1:0]  up_q, up_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        sync_s0_d = btn_in ^ POL_MASK;
        sync_s1_d = sync_s0_q;
        state_d   = state_q;
        down_d    = '0;
        up_d      = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_s1_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                state_d[i] = sync_s1_q[i];
                cnt_d[i]   = '0;
                down_d[i]  = sync_s1_q[i];
                up_d[i]    = ~sync_s1_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Zero is the released level after polarity correction, so a held pin is re-debounced.
            sync_s0_q <= '0;
            sync_s1_q <= '0;
            state_q   <= '0;
            down_q    <= '0;
            up_q      <= '0;
            // NOTE: the counter array is reset explicitly; stale counts must not survive reset.
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            sync_s0_q <= sync_s0_d;
            sync_s1_q <= sync_s1_d;
            state_q   <= state_d;
            down_q    <= down_d;
            up_q      <= up_d;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_state = state_q;
    assign btn_down  = down_q;
    assign btn_up    = up_q;

`ifdef HOLD_REPEAT_EN
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_RPT
    } rpt_state_e;

    rpt_state_e       rpt_state_q [N_CH];
    rpt_state_e       rpt_state_d [N_CH];
    logic [TMR_W-1:0] tmr_q [N_CH];
    logic [TMR_W-1:0] tmr_d [N_CH];
    logic [N_CH-1:0]  repeat_q, repeat_d;

    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            rpt_state_d[i] = rpt_state_q[i];
            tmr_d[i]       = tmr_q[i];
            // An accepted release overrides any repeat that would fall due in the same cycle.
            if (up_d[i]) begin
                rpt_state_d[i] = RPT_IDLE;
                tmr_d[i]       = '0;
            end else begin
                case (rpt_state_q[i])
                    RPT_IDLE: begin
                        if (down_d[i]) begin
                            rpt_state_d[i] = RPT_HOLD;
                            tmr_d[i]       = '0;
                        end
                    end
                    RPT_HOLD: begin
                        if (tmr_q[i] == HOLD_LAST) begin
                            repeat_d[i]    = 1'b1;
                            tmr_d[i]       = '0;
                            rpt_state_d[i] = RPT_RPT;
                        end else begin
                            tmr_d[i] = tmr_q[i] + TMR_W'(1);
                        end
                    end
                    RPT_RPT: begin
                        if (tmr_q[i] == RPT_LAST) begin
                            repeat_d[i] = 1'b1;
                            tmr_d[i]    = '0;
                        end else begin
                            tmr_d[i] = tmr_q[i] + TMR_W'(1);
                        end
                    end
                    default: begin
                        rpt_state_d[i] = RPT_IDLE;
                        tmr_d[i]       = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            repeat_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                rpt_state_q[i] <= RPT_IDLE;
                tmr_q[i]       <= '0;
            end
        end else begin
            repeat_q <= repeat_d;
            for (int i = 0; i < N_CH; i++) begin
                rpt_state_q[i] <= rpt_state_d[i];
                tmr_q[i]       <= tmr_d[i];
            end
        end
    end

    assign btn_repeat = repeat_q;
`else
    assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer (N_CH=4, DEBOUNCE_CYCLES=8, HOLD=20, REPEAT=5, active-low pins).
// Outputs are sampled on the falling edge; pins are driven right after each sample.
module tb_multi_button_debouncer;

    localparam int N_CH = 4;
`ifdef HOLD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_state, btn_down, btn_up, btn_repeat;

    int errors = 0;
    int checks = 0;

    multi_button_debouncer #(
        .N_CH           (N_CH),
        .DEBOUNCE_CYCLES(8),
        .ACTIVE_LOW     (1),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .btn_state (btn_state),
        .btn_down  (btn_down),
        .btn_up    (btn_up),
        .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected vector is {state, down, up, repeat}, one nibble each.
    task automatic chk(input string tag, input int cyc, input logic [15:0] exp);
        logic [15:0] obs;
        obs = {btn_state, btn_down, btn_up, btn_repeat};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed st/dn/up/rp=%h required %h", tag, cyc, obs, exp);
        end
    endtask

    // Nine quiet cycles at the old level, then the new level with its pulse on the tenth.
    task automatic wait_edge(input string tag, input logic [3:0] st_before, input logic [3:0] st_after,
                             input logic [3:0] dn, input logic [3:0] up);
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            chk(tag, k, {st_before, 4'h0, 4'h0, 4'h0});
        end
        tick(1);
        chk(tag, 10, {st_after, dn, up, 4'h0});
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 4'b1111;

        // 1. reset state, then 50 idle cycles with all pins released
        tick(3);
        chk("reset", 0, 16'h0000);
        reset = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            chk("idle", k, 16'h0000);
        end

        // 2. clean press and release on ch0
        btn_in[0] = 1'b0;
        wait_edge("ch0_press", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        tick(1);
        chk("ch0_down_once", 11, {4'b0001, 4'h0, 4'h0, 4'h0});
        btn_in[0] = 1'b1;
        wait_edge("ch0_release", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        tick(1);
        chk("ch0_up_once", 11, 16'h0000);

        // 3. ch1 bounces every 3 cycles, then settles pressed
        for (int b = 0; b < 4; b++) begin
            btn_in[1] = b[0];
            for (int k = 1; k <= 3; k++) begin
                tick(1);
                chk("ch1_bounce", b * 3 + k, 16'h0000);
            end
        end
        btn_in[1] = 1'b0;
        wait_edge("ch1_settle", 4'b0000, 4'b0010, 4'b0010, 4'b0000);
        for (int k = 11; k <= 13; k++) begin
            tick(1);
            chk("ch1_single_down", k, {4'b0010, 4'h0, 4'h0, 4'h0});
        end
        btn_in[1] = 1'b1;
        wait_edge("ch1_release", 4'b0010, 4'b0000, 4'b0000, 4'b0010);

        // 4. ch2 and ch3 pressed together
        btn_in[3:2] = 2'b00;
        wait_edge("ch23_press", 4'b0000, 4'b1100, 4'b1100, 4'b0000);
        tick(1);
        chk("ch23_held", 11, {4'b1100, 4'h0, 4'h0, 4'h0});
        btn_in[3:2] = 2'b11;
        wait_edge("ch23_release", 4'b1100, 4'b0000, 4'b0000, 4'b1100);

        // 5. ch0 held 60 cycles after btn_down, then released
        btn_in[0] = 1'b0;
        wait_edge("ch0_hold_press", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        for (int k = 1; k <= 60; k++) begin
            logic rp;
            rp = REP_EN && (k >= 20) && ((k - 20) % 5 == 0);
            tick(1);
            chk("ch0_repeat", k, {4'b0001, 4'h0, 4'h0, 3'b000, rp});
        end
        btn_in[0] = 1'b1;
        for (int k = 61; k <= 70; k++) begin
            logic rp;
            rp = REP_EN && (k == 65);
            tick(1);
            if (k < 70) chk("ch0_repeat_tail", k, {4'b0001, 4'h0, 4'h0, 3'b000, rp});
            else        chk("ch0_hold_up", k, {4'b0000, 4'h0, 4'b0001, 4'h0});
        end
        for (int k = 71; k <= 100; k++) begin
            tick(1);
            chk("ch0_no_repeat_after_up", k, 16'h0000);
        end

        // 6. one-cycle reset while ch0 is pressed mid-hold
        btn_in[0] = 1'b0;
        wait_edge("ch0_press2", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("ch0_midhold", k, {4'b0001, 4'h0, 4'h0, 4'h0});
        end
        reset = 1'b1;
        tick(1);
        chk("midhold_reset", 0, 16'h0000);
        reset = 1'b0;
        wait_edge("ch0_redebounce", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        btn_in[0] = 1'b1;
        wait_edge("ch0_final_release", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        tick(2);
        chk("final_idle", 0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
